// File: rtl/ntt_intt_load_seq.sv
// Load sequencer for the Kyber NTT/INTT core: unpacks 32-bit words into two
// reduced coefficients, streams them to the core and sequences load/start/done.
module ntt_intt_load_seq #(
    parameter int N_COEFFS = 256,
    parameter int Q        = 3329,
    parameter int COEF_W   = 16,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    output logic              load_a_f_o,
    output logic              load_a_i_o,
    output logic [DATA_W-1:0] din_o,
    output logic              din_en_o,
    output logic              start_fntt_o,
    output logic              start_intt_o,
    input  logic              core_done_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  coef_cnt_o
);

    localparam int RED_W = $clog2(Q);
    localparam logic [CNT_W-1:0] N_FULL  = CNT_W'(N_COEFFS);
    localparam logic [CNT_W-1:0] N_WORDS = CNT_W'(N_COEFFS / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_START,
        S_RUN
    } state_t;

    state_t             state_q;
    logic               mode_q;
    logic [COEF_W-1:0]  hold_q;
    logic               hv_q;
    logic               half_q;
    logic [RED_W-1:0]   din_q;
    logic               din_en_q;
    logic [CNT_W-1:0]   words_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic               ld_f_q;
    logic               ld_i_q;
    logic               st_f_q;
    logic               st_i_q;
    logic               done_q;

    logic               accept;
    logic               emit_hi;
    logic [COEF_W-1:0]  word_lo;
    logic [COEF_W-1:0]  word_hi;
    logic [RED_W-1:0]   din_d;
    logic               bad_d;

    // Single conditional subtraction; anything at or above 2Q is flagged and zeroed.
    function automatic logic [RED_W-1:0] reduce_coef(input logic [COEF_W-1:0] c);
        logic [COEF_W-1:0] diff;
        diff = c - COEF_W'(Q);
        if (c < COEF_W'(Q))
            reduce_coef = c[RED_W-1:0];
        else if (c < COEF_W'(2 * Q))
            reduce_coef = diff[RED_W-1:0];
        else
            reduce_coef = '0;
    endfunction

    function automatic logic coef_bad(input logic [COEF_W-1:0] c);
        coef_bad = (c >= COEF_W'(2 * Q));
    endfunction

    assign word_lo = word_i[COEF_W-1:0];
    assign word_hi = word_i[2*COEF_W-1:COEF_W];

    // The holding register frees up while its high half is on din_o, so a new
    // word can land exactly when the previous one has been fully emitted.
    assign word_ready_o = (state_q == S_FILL) && (words_q < N_WORDS) && (!hv_q || half_q);
    assign accept       = word_valid_i && word_ready_o;
    assign emit_hi      = hv_q && !half_q;
    assign din_d        = accept ? reduce_coef(word_lo) : reduce_coef(hold_q);
    assign bad_d        = accept ? coef_bad(word_lo) : coef_bad(hold_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            hold_q   <= '0;
            hv_q     <= 1'b0;
            half_q   <= 1'b0;
            din_q    <= '0;
            din_en_q <= 1'b0;
            words_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            ld_f_q   <= 1'b0;
            ld_i_q   <= 1'b0;
            st_f_q   <= 1'b0;
            st_i_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            ld_f_q   <= 1'b0;
            ld_i_q   <= 1'b0;
            st_f_q   <= 1'b0;
            st_i_q   <= 1'b0;
            done_q   <= 1'b0;
            din_en_q <= 1'b0;
            if (clear_i) begin
                state_q <= S_IDLE;
                hv_q    <= 1'b0;
                half_q  <= 1'b0;
                words_q <= '0;
                cnt_q   <= '0;
                err_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            mode_q  <= mode_i;
                            cnt_q   <= '0;
                            words_q <= '0;
                            hv_q    <= 1'b0;
                            half_q  <= 1'b0;
                            ld_f_q  <= !mode_i;
                            ld_i_q  <= mode_i;
                            state_q <= S_LOAD;
                        end
                    end
                    S_LOAD: state_q <= S_FILL;
                    S_FILL: begin
                        if (cnt_q == N_FULL) begin
                            state_q <= S_START;
                            st_f_q  <= !mode_q;
                            st_i_q  <= mode_q;
                            hv_q    <= 1'b0;
                        end else begin
                            if (accept || emit_hi) begin
                                din_q    <= din_d;
                                din_en_q <= 1'b1;
                                cnt_q    <= cnt_q + CNT_W'(1);
                                if (bad_d)
                                    err_q <= 1'b1;
                            end
                            if (accept) begin
                                hold_q  <= word_hi;
                                hv_q    <= 1'b1;
                                half_q  <= 1'b0;
                                words_q <= words_q + CNT_W'(1);
                            end else if (emit_hi) begin
                                half_q <= 1'b1;
                            end else if (half_q) begin
                                hv_q <= 1'b0;
                            end
                        end
                    end
                    S_START: state_q <= S_RUN;
                    S_RUN: begin
                        if (core_done_i) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign load_a_f_o   = ld_f_q;
    assign load_a_i_o   = ld_i_q;
    assign start_fntt_o = st_f_q;
    assign start_intt_o = st_i_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign din_en_o     = din_en_q;
    assign din_o        = DATA_W'(din_q);
    assign coef_cnt_o   = cnt_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ntt_intt_load_seq.sv
// Scoreboard bench for ntt_intt_load_seq: driver pushes expected coefficients,
// a negedge monitor pops and compares them and counts strobes.
module tb_ntt_intt_load_seq;

    localparam int N = 256;
    localparam int Q = 3329;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        mode_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [31:0] word_i = '0;
    logic        word_valid_i = 1'b0;
    logic        core_done_i = 1'b0;
    logic        word_ready_o;
    logic        load_a_f_o;
    logic        load_a_i_o;
    logic [31:0] din_o;
    logic        din_en_o;
    logic        start_fntt_o;
    logic        start_intt_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [8:0]  coef_cnt_o;

    ntt_intt_load_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .clear_i      (clear_i),
        .word_i       (word_i),
        .word_valid_i (word_valid_i),
        .word_ready_o (word_ready_o),
        .load_a_f_o   (load_a_f_o),
        .load_a_i_o   (load_a_i_o),
        .din_o        (din_o),
        .din_en_o     (din_en_o),
        .start_fntt_o (start_fntt_o),
        .start_intt_o (start_intt_o),
        .core_done_i  (core_done_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .coef_cnt_o   (coef_cnt_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int n_ldf = 0, n_ldi = 0, n_stf = 0, n_sti = 0, n_done = 0;
    int run_len = 0;
    bit model_err = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int ref_red(input int c);
        if (c < Q) return c;
        if (c < 2 * Q) return c - Q;
        return 0;
    endfunction

    function automatic logic [15:0] rand_field(input bit allow_bad);
        if (allow_bad && $urandom_range(0, 99) < 5)
            return 16'($urandom_range(2 * Q, 65535));
        return 16'($urandom_range(0, 2 * Q - 1));
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (din_en_o) begin
                run_len++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL din_unexpected: got din=%0d, expected no output", din_o);
                end else begin
                    chk("din", int'(din_o), exp_q.pop_front());
                end
            end else begin
                run_len = 0;
            end
            if (load_a_f_o) n_ldf++;
            if (load_a_i_o) n_ldi++;
            if (start_fntt_o) n_stf++;
            if (start_intt_o) n_sti++;
            if (done_o) n_done++;
            if (start_fntt_o || start_intt_o) chk("cnt_at_start", int'(coef_cnt_o), N);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input bit m);
        start_i = 1'b1;
        mode_i  = m;
        cyc(1);
        start_i = 1'b0;
        chk("load_a_f_pulse", int'(load_a_f_o), int'(!m));
        chk("load_a_i_pulse", int'(load_a_i_o), int'(m));
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
        exp_q.delete();
        model_err = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input int gap);
        bit ok;
        int t;
        logic [15:0] lo, hi;
        ok = 1'b0;
        t = 0;
        lo = w[15:0];
        hi = w[31:16];
        word_i = w;
        word_valid_i = 1'b1;
        while (!ok && t < 100) begin
            @(negedge clk);
            if (word_ready_o) begin
                ok = 1'b1;
                exp_q.push_back(ref_red(int'(lo)));
                exp_q.push_back(ref_red(int'(hi)));
                if (int'(lo) >= 2 * Q || int'(hi) >= 2 * Q) model_err = 1'b1;
            end
            @(posedge clk);
            #1;
            t++;
        end
        word_valid_i = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL word_accept_timeout: got ready=0 for %0d cycles, expected acceptance", t);
        end
        cyc(gap);
    endtask

    task automatic wait_start_strobe();
        int t;
        t = 0;
        while (!(start_fntt_o || start_intt_o) && t < 2000) begin
            cyc(1);
            t++;
        end
        if (t >= 2000) begin
            checks++;
            errors++;
            $display("FAIL start_strobe_timeout: got no strobe in %0d cycles, expected one", t);
        end
    endtask

    task automatic finish_run();
        cyc(1);
        core_done_i = 1'b1;
        cyc(1);
        core_done_i = 1'b0;
        chk("done_pulse", int'(done_o), 1);
        chk("busy_after_done", int'(busy_o), 0);
        cyc(1);
        chk("done_single", int'(done_o), 0);
    endtask

    // kind: 0 = ramp 0..255, 1 = random with some >= 2Q fields
    task automatic run_load(input bit m, input int kind, input bit var_gap, input bit poke_run);
        int ldf0, ldi0, stf0, sti0, dn0, g;
        logic [31:0] w;
        ldf0 = n_ldf; ldi0 = n_ldi; stf0 = n_stf; sti0 = n_sti; dn0 = n_done;
        do_start(m);
        for (int k = 0; k < N / 2; k++) begin
            if (kind == 0) w = {16'(2 * k + 1), 16'(2 * k)};
            else w = {rand_field(1'b1), rand_field(1'b1)};
            g = var_gap ? $urandom_range(1, 3) : 0;
            send(w, g);
        end
        wait_start_strobe();
        chk("start_fntt", int'(start_fntt_o), int'(!m));
        chk("start_intt", int'(start_intt_o), int'(m));
        chk("queue_drained", exp_q.size(), 0);
        if (kind == 0 && !var_gap) chk("din_run_len", run_len, N);
        chk("load_f_count", n_ldf - ldf0, int'(!m));
        chk("load_i_count", n_ldi - ldi0, int'(m));
        if (poke_run) begin
            cyc(1);
            start_i = 1'b1;
            mode_i = !m;
            cyc(3);
            start_i = 1'b0;
            cyc(1);
            chk("run_start_ignored_busy", int'(busy_o), 1);
            chk("run_start_no_load", (n_ldf - ldf0) + (n_ldi - ldi0), 1);
            core_done_i = 1'b1;
            cyc(1);
            core_done_i = 1'b0;
            chk("done_pulse", int'(done_o), 1);
            chk("busy_after_done", int'(busy_o), 0);
            cyc(1);
        end else begin
            finish_run();
        end
        chk("start_f_count", n_stf - stf0, int'(!m));
        chk("start_i_count", n_sti - sti0, int'(m));
        chk("done_count", n_done - dn0, 1);
        chk("err_sticky", int'(err_o), int'(model_err));
    endtask

    initial begin
        int stf0, sti0, ldi0;
        cyc(3);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_ready", int'(word_ready_o), 0);
        chk("rst_din_en", int'(din_en_o), 0);
        chk("rst_cnt", int'(coef_cnt_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_strobes", int'({load_a_f_o, load_a_i_o, start_fntt_o, start_intt_o, done_o}), 0);
        rst_n = 1'b1;
        cyc(2);

        // back-to-back ramp in NTT mode
        run_load(1'b0, 0, 1'b0, 1'b0);
        // INTT with gaps, random data, start poked during RUN
        run_load(1'b1, 1, 1'b1, 1'b1);

        // reduction boundaries and err stickiness
        pulse_clear();
        chk("err_cleared", int'(err_o), 0);
        do_start(1'b0);
        send(32'h0D010D00, 0);
        cyc(2);
        chk("err_after_3328_3329", int'(err_o), 0);
        send(32'h1A020D02, 0);
        cyc(2);
        chk("err_after_6658", int'(err_o), 1);
        for (int k = 0; k < N / 2 - 2; k++) send({rand_field(1'b0), rand_field(1'b0)}, 0);
        wait_start_strobe();
        chk("queue_drained_red", exp_q.size(), 0);
        finish_run();
        chk("err_through_done", int'(err_o), 1);
        pulse_clear();
        chk("err_clear", int'(err_o), 0);

        // clear and start together in IDLE
        clear_i = 1'b1;
        start_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
        start_i = 1'b0;
        chk("clr_start_busy", int'(busy_o), 0);
        chk("clr_start_load", int'(load_a_f_o), 0);

        // abort after 100 coefficients
        do_start(1'b0);
        for (int k = 0; k < 50; k++) send({rand_field(1'b0), rand_field(1'b0)}, 0);
        cyc(3);
        chk("abort_cnt_before", int'(coef_cnt_o), 100);
        chk("abort_queue", exp_q.size(), 0);
        stf0 = n_stf; sti0 = n_sti;
        pulse_clear();
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_cnt", int'(coef_cnt_o), 0);
        chk("abort_ready", int'(word_ready_o), 0);
        cyc(5);
        chk("abort_no_start", (n_stf - stf0) + (n_sti - sti0), 0);
        run_load(1'b0, 1, 1'b0, 1'b0);

        // asynchronous reset mid-FILL
        pulse_clear();
        do_start(1'b1);
        for (int k = 0; k < 40; k++) send({rand_field(1'b0), rand_field(1'b0)}, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_din_en", int'(din_en_o), 0);
        chk("arst_cnt", int'(coef_cnt_o), 0);
        chk("arst_din", int'(din_o), 0);
        chk("arst_ready", int'(word_ready_o), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        model_err = 1'b0;
        stf0 = n_stf; sti0 = n_sti; ldi0 = n_ldi;
        cyc(10);
        chk("arst_no_strobes", (n_stf - stf0) + (n_sti - sti0) + (n_ldi - ldi0), 0);
        chk("arst_idle", int'(busy_o), 0);
        run_load(1'b1, 1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ntt_intt_load_seq.md
Name: ntt_intt_load_seq

Overview:
- Upstream load sequencer for the Kyber NTT/INTT core.
- Accepts packed 32-bit words from the bus/register-file side with a valid/ready handshake.
- Each word is unpacked into two coefficients and reduced into [0,Q). Coefficients stream into the core's din/din_en port at one per cycle.
- Issues the core's load strobe before streaming and the start_fntt/start_intt strobe after streaming, then waits for the core's done.

Parameters:
- N_COEFFS, 256, coefficients per polynomial (even).
- Q, 3329, Kyber modulus.
- COEF_W, 16, packed coefficient field width (two per word).
- DATA_W, 32, word and din width.
- CNT_W, 9, coefficient counter width (must hold N_COEFFS).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  start a load+transform; sampled only in IDLE
- mode_i  in  1  0=NTT, 1=INTT; latched on accepted start_i
- clear_i  in  1  synchronous abort; returns to IDLE, clears err_o
- word_i  in  DATA_W  packed word: [15:0] even coefficient, [31:16] odd coefficient
- word_valid_i  in  1  word_i valid
- word_ready_o  out  1  word accepted when valid&&ready
- load_a_f_o  out  1  one-cycle load strobe to core, NTT mode
- load_a_i_o  out  1  one-cycle load strobe to core, INTT mode
- din_o  out  DATA_W  coefficient to core, zero-extended
- din_en_o  out  1  din_o valid this cycle
- start_fntt_o  out  1  one-cycle start strobe, NTT mode
- start_intt_o  out  1  one-cycle start strobe, INTT mode
- core_done_i  in  1  core transform complete
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse when core_done_i is seen in RUN
- err_o  out  1  sticky: a coefficient was >= 2Q
- coef_cnt_o  out  CNT_W  coefficients emitted in the current load

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, counters 0, holding register empty, err_o 0. Reset mid-operation abandons the load; no strobes are issued after release.
- FSM states: IDLE, LOAD, FILL, START, RUN.
- IDLE: start_i=1 latches mode, clears coef_cnt, goes to LOAD.
- LOAD: lasts exactly one cycle. Drives load_a_f_o (mode 0) or load_a_i_o (mode 1) high for that cycle, then goes to FILL.
- FILL: streams coefficients; transitions are defined in the streaming bullets below.
- START: lasts exactly one cycle. Drives start_fntt_o or start_intt_o high, then goes to RUN.
- RUN: waits for core_done_i=1. done_o pulses high on the same cycle the FSM registers IDLE. Only then is a new start_i accepted.
- start_i in any state other than IDLE is ignored.
- Streaming in FILL:
  - The holding register stores one word plus a half-select bit.
  - word_ready_o = FILL && words_accepted < N_COEFFS/2 && (holding empty || high half emitted this cycle).
  - A word accepted in cycle k gives its even coefficient on din_o/din_en_o in cycle k+1 and its odd coefficient in cycle k+2.
  - Back-to-back valid words sustain din_en_o=1 every cycle.
  - word_valid_i low leaves gaps with din_en_o=0; din_o holds its last value.
- Reduction per 16-bit field c:
  - c < Q: output c.
  - Q <= c < 2Q: output c-Q.
  - c >= 2Q: output 0 and set err_o.
  - Output is 12 bits, zero-extended to DATA_W.
- coef_cnt_o increments on every din_en_o cycle.
- When coef_cnt reaches N_COEFFS (the last coefficient has been emitted), the next state is START. No wrap-around: word_ready_o stays 0 once N_COEFFS/2 words have been accepted.
- clear_i (any state) has priority over all else:
  - next cycle: IDLE, holding register emptied, counters and err_o cleared;
  - no load, start or done strobes are produced that cycle.
- clear_i and start_i together in IDLE: clear wins and start_i is dropped.
- err_o persists through done_o and until clear_i or reset. It does not block the sequence.

Test Plan:
- NTT load: start_i, mode_i=0, 128 back-to-back words {2k+1,2k} -> exactly one load_a_f_o pulse, din_en_o high for 256 consecutive cycles with din_o=0,1,…,255, then one start_fntt_o pulse, no load_a_i_o or start_intt_o. core_done_i -> done_o pulse, busy_o=0.
- INTT load with word_valid_i toggling 1/0 -> din_en_o gaps match, order preserved, coef_cnt_o=256 at the start_intt_o pulse.
- Reduction: word 0x0D010D00 (even 3328, odd 3329) -> din_o 3328 then 0, err_o=0. Word 0x1A020D02 (even 3330, odd 6658) -> din_o 1 then 0, err_o=1 and held sticky until clear_i.
- Abort: clear_i after 100 coefficients -> IDLE next cycle, no start strobe, coef_cnt_o=0. A fresh start then completes normally.
- Async reset mid-FILL: rst_n low for 3 cycles -> all outputs 0 immediately. start_i during RUN -> ignored, no second load strobe.
